// File: rtl/calc_entry_fsm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : calc_entry_fsm_pkg
//  Description : Keypad codes, state encoding and operator codes shared by the
//                calculator entry controller and its key-event decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package calc_entry_fsm_pkg;

    // Keypad scanner codes
    localparam logic [4:0] KEY_0    = 5'd0;
    localparam logic [4:0] KEY_9    = 5'd9;
    localparam logic [4:0] KEY_A    = 5'd10;
    localparam logic [4:0] KEY_B    = 5'd11;
    localparam logic [4:0] KEY_C    = 5'd12;
    localparam logic [4:0] KEY_D    = 5'd13;
    localparam logic [4:0] KEY_STAR = 5'd14;
    localparam logic [4:0] KEY_NONE = 5'd31;

    // Operator codes presented to the ALU
    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;

    // Controller states; the encoding is visible on the st output
    typedef enum logic [2:0] {
        ST_ENT_A = 3'd0,
        ST_ENT_B = 3'd1,
        ST_CALC  = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

    // Map an operator key (A/B/C) to its ALU operator code
    function automatic logic [1:0] key_to_op(input logic [4:0] k);
        case (k)
            KEY_B:   key_to_op = OP_SUB;
            KEY_C:   key_to_op = OP_MUL;
            default: key_to_op = OP_ADD;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/calc_entry_fsm_key_event.sv
`default_nettype none
// ============================================================================
//  Module      : calc_key_event
//  Description : Edge detector for keypad codes. A press is a defined key that
//                follows a KEY_NONE cycle, so held keys and key-to-key slides
//                without a release produce no event.
//  Revision    : 1.0 - initial release
// ============================================================================
module calc_key_event
    import calc_entry_fsm_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] key,
    output logic       press,
    output logic       is_digit,
    output logic       is_op,
    output logic [3:0] digit
);

    logic [4:0] r_key_prev;

    // Remember last cycle's key code; reset as if no key were down
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_key_prev <= KEY_NONE;
        end else begin
            r_key_prev <= key;
        end
    end

    // Codes 15..30 are never treated as a press
    assign press    = (key != KEY_NONE) && (r_key_prev == KEY_NONE) && (key <= KEY_STAR);
    assign is_digit = (key <= KEY_9);
    assign is_op    = (key >= KEY_A) && (key <= KEY_C);
    assign digit    = key[3:0];

endmodule
`default_nettype wire

// File: rtl/calc_entry_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : calc_entry_fsm
//  Description : Keypad entry controller. Collects two BCD operands and an
//                operator, starts the ALU with a one-cycle pulse and waits for
//                end_obl with a timeout into an error state.
//  Revision    : 1.0 - initial release
// ============================================================================
module calc_entry_fsm
    import calc_entry_fsm_pkg::*;
#(
    parameter int DIGITS  = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [4:0]                   key,
    input  logic                         end_obl,
    output logic [4*DIGITS-1:0]          opa,
    output logic [4*DIGITS-1:0]          opb,
    output logic [1:0]                   op,
    output logic                         calc_start,
    output logic [2:0]                   st,
    output logic [$clog2(DIGITS+1)-1:0]  dig_cnt,
    output logic                         key_rej,
    output logic                         err
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);
    localparam int TW = $clog2(TIMEOUT);

    logic          w_press;
    logic          w_is_digit;
    logic          w_is_op;
    logic [3:0]    w_digit;
    logic          w_star;
    logic          w_full;

    state_t        r_state, n_state;
    logic [W-1:0]  r_opa,   n_opa;
    logic [W-1:0]  r_opb,   n_opb;
    logic [1:0]    r_op,    n_op;
    logic [CW-1:0] r_cnt,   n_cnt;
    logic [TW-1:0] r_timer, n_timer;
    logic          r_rej,   n_rej;

    calc_key_event u_key_event (
        .clk      (clk),
        .rst      (rst),
        .key      (key),
        .press    (w_press),
        .is_digit (w_is_digit),
        .is_op    (w_is_op),
        .digit    (w_digit)
    );

    assign w_star = w_press && (key == KEY_STAR);
    assign w_full = (r_cnt == CW'(DIGITS));

    // State, operand, timer and reject-pulse registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_ENT_A;
            r_opa   <= '0;
            r_opb   <= '0;
            r_op    <= OP_ADD;
            r_cnt   <= '0;
            r_timer <= '0;
            r_rej   <= 1'b0;
        end else begin
            r_state <= n_state;
            r_opa   <= n_opa;
            r_opb   <= n_opb;
            r_op    <= n_op;
            r_cnt   <= n_cnt;
            r_timer <= n_timer;
            r_rej   <= n_rej;
        end
    end

    // Next-state and datapath decisions; STAR overrides everything
    always_comb begin
        n_state = r_state;
        n_opa   = r_opa;
        n_opb   = r_opb;
        n_op    = r_op;
        n_cnt   = r_cnt;
        n_timer = r_timer;
        n_rej   = 1'b0;
        if (w_star) begin
            n_state = ST_ENT_A;
            n_opa   = '0;
            n_opb   = '0;
            n_op    = OP_ADD;
            n_cnt   = '0;
        end else begin
            case (r_state)
                ST_ENT_A: begin
                    if (w_press) begin
                        if (w_is_digit) begin
                            if (w_full) begin
                                n_rej = 1'b1;
                            end else begin
                                n_opa = W'({r_opa, w_digit});
                                n_cnt = r_cnt + CW'(1);
                            end
                        end else if (w_is_op && (r_cnt != '0)) begin
                            n_op    = key_to_op(key);
                            n_opb   = '0;
                            n_cnt   = '0;
                            n_state = ST_ENT_B;
                        end else begin
                            n_rej = 1'b1;
                        end
                    end
                end
                ST_ENT_B: begin
                    if (w_press) begin
                        if (w_is_digit) begin
                            if (w_full) begin
                                n_rej = 1'b1;
                            end else begin
                                n_opb = W'({r_opb, w_digit});
                                n_cnt = r_cnt + CW'(1);
                            end
                        end else if (w_is_op && (r_cnt == '0)) begin
                            n_op = key_to_op(key);
                        end else if ((key == KEY_D) && (r_cnt != '0)) begin
                            n_timer = '0;
                            n_state = ST_CALC;
                        end else begin
                            n_rej = 1'b1;
                        end
                    end
                end
                ST_CALC: begin
                    // Non-STAR keys are ignored here without a reject pulse
                    n_timer = r_timer + TW'(1);
                    if (end_obl) begin
                        n_state = ST_DONE;
                    end else if (r_timer == TW'(TIMEOUT - 1)) begin
                        n_state = ST_ERR;
                    end
                end
                ST_DONE: begin
                    if (w_press) begin
                        if (w_is_digit) begin
                            n_opa   = W'(w_digit);
                            n_opb   = '0;
                            n_cnt   = CW'(1);
                            n_state = ST_ENT_A;
                        end else begin
                            n_rej = 1'b1;
                        end
                    end
                end
                ST_ERR: begin
                    if (w_press) begin
                        n_rej = 1'b1;
                    end
                end
                default: begin
                    n_state = ST_ENT_A;
                end
            endcase
        end
    end

    // The timer is cleared on CALC entry, so timer==0 marks the first CALC cycle
    assign calc_start = (r_state == ST_CALC) && (r_timer == '0);
    assign err        = (r_state == ST_ERR);
    assign st         = r_state;
    assign opa        = r_opa;
    assign opb        = r_opb;
    assign op         = r_op;
    assign dig_cnt    = r_cnt;
    assign key_rej    = r_rej;

endmodule
`default_nettype wire
